// File: rtl/sccb_slave_regif.sv
// SCCB slave front end: decodes device address, 16-bit register pointer,
// write bursts (wr_valid strobes) and read bursts (rd_addr lookup, rd_data shift-out).
module sccb_slave_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy
);

  // state   | meaning
  // IDLE    | bus free, wait START      DEV     | shift in device byte
  // ACK_*   | pull SDA for 9th clock    REG_*   | pointer high/low byte
  // WDATA   | write data byte           RDATA   | shift out rd_data
  // RACK    | sample master ACK         IGNORE  | not addressed / NACKed
  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO,
    WDATA, ACK_W, RDATA, RACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  // SCL must be high on both samples, so START/STOP can never alias an SCL edge
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q, rx_d, tx_q, tx_d;
  logic [7:0]  hi_q, hi_d, wr_data_q, wr_data_d, rx_byte;
  logic [15:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic        rw_q, rw_d, oe_q, oe_d, wr_valid_q, wr_valid_d, busy_q, busy_d;
  logic        byte_done, shifting;

  assign rx_byte   = {rx_q, sda_s};
  assign byte_done = (bit_cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = DEV;
    end else if (stop_det) begin
      state_d = IDLE;
    end else if (scl_rise) begin
      case (state_q)
        DEV:     if (byte_done) state_d = (rx_byte[7:1] == DEV_ADDR) ? ACK_DEV : IGNORE;
        ACK_DEV: state_d = rw_q ? RDATA : REG_HI;
        REG_HI:  if (byte_done) state_d = ACK_HI;
        ACK_HI:  state_d = REG_LO;
        REG_LO:  if (byte_done) state_d = ACK_LO;
        ACK_LO:  state_d = WDATA;
        WDATA:   if (byte_done) state_d = ACK_W;
        ACK_W:   state_d = WDATA;
        RDATA:   if (byte_done) state_d = RACK;
        RACK:    state_d = sda_s ? IGNORE : RDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    hi_d       = hi_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    shifting   = (state_q == DEV) || (state_q == REG_HI) || (state_q == REG_LO) ||
                 (state_q == WDATA) || (state_q == RDATA);
    if (start_det) begin
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
      busy_d    = 1'b0;
    end else begin
      if (state_q == ACK_DEV) busy_d = 1'b1;
      if (scl_rise) begin
        if (shifting) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        case (state_q)
          DEV:    if (byte_done) rw_d = sda_s;
          REG_HI: if (byte_done) hi_d = rx_byte;
          REG_LO: if (byte_done) ptr_d = {hi_q, rx_byte};
          WDATA: begin
            if (byte_done) begin
              wr_valid_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = rx_byte;
            end
          end
          ACK_W:  ptr_d = ptr_q + 16'd1;
          RACK:   if (!sda_s) ptr_d = ptr_q + 16'd1;
          default: ;
        endcase
      end
      if (scl_fall) begin
        case (state_q)
          ACK_DEV, ACK_HI, ACK_LO, ACK_W: oe_d = 1'b1;
          RDATA: begin
            if (bit_cnt_q == 3'd0) begin
              tx_d = rd_data[6:0];
              oe_d = ~rd_data[7];
            end else begin
              tx_d = {tx_q[5:0], 1'b0};
              oe_d = ~tx_q[6];
            end
          end
          default: oe_d = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 7'd0;
      hi_q       <= 8'd0;
      ptr_q      <= 16'd0;
      rw_q       <= 1'b0;
      oe_q       <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'd0;
      wr_data_q  <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      hi_q       <= hi_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_oe   = oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_addr  = ptr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sccb_slave_regif.sv
// Bench for sccb_slave_regif: bit-banged SCCB master on an open-drain SDA model,
// write/read scoreboards fed as stimulus is issued.
module tb_sccb_slave_regif;
  localparam int Q = 10;
  localparam int H = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        scl_in, sda_in;
  logic        sda_oe, wr_valid, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic        oe_seen = 1'b0;
  logic        busy_seen = 1'b0;
  int          wr_seen = 0;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  sccb_slave_regif #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  function automatic logic [7:0] reg_val(input logic [15:0] a);
    return (a == 16'h300A) ? 8'h56 : (a[7:0] ^ a[15:8] ^ 8'hA5);
  endfunction

  // register file model: contents of rd_addr appear within one clk
  always @(negedge clk) rd_data = reg_val(rd_addr);

  always @(negedge clk) begin
    logic [23:0] exp;
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (!rst && wr_valid) begin
      wr_seen++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got addr=%h data=%h, none expected", wr_addr, wr_data);
      end else begin
        exp = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          failures++;
          $display("FAIL wr_pair got addr=%h data=%h expected addr=%h data=%h",
                   wr_addr, wr_data, exp[23:8], exp[7:0]);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H / 2);
    ack = sda_in;
    wait_clk(H / 2);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(H / 2);
      b[i] = sda_in;
      wait_clk(H / 2);
      scl_m = 1'b0; wait_clk(Q);
    end
    sda_m = ack_bit; wait_clk(Q);
    scl_m = 1'b1;    wait_clk(H);
    scl_m = 1'b0;    wait_clk(Q);
    sda_m = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wait_clk(5);
    rst = 1'b0; wait_clk(2);
    checks += 6;
    if (sda_oe !== 1'b0)     begin failures++; $display("FAIL rst_sda_oe got %b expected 0", sda_oe); end
    if (wr_valid !== 1'b0)   begin failures++; $display("FAIL rst_wr_valid got %b expected 0", wr_valid); end
    if (wr_addr !== 16'h0)   begin failures++; $display("FAIL rst_wr_addr got %h expected 0000", wr_addr); end
    if (wr_data !== 8'h0)    begin failures++; $display("FAIL rst_wr_data got %h expected 00", wr_data); end
    if (rd_addr !== 16'h0)   begin failures++; $display("FAIL rst_rd_addr got %h expected 0000", rd_addr); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got %b expected 0", busy); end
  endtask

  task automatic test_single_write();
    logic [7:0] wb[4];
    logic ack;
    wb = '{8'h78, 8'h31, 8'h03, 8'h11};
    exp_wr_q.push_back({16'h3103, 8'h11});
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL single_ack[%0d] got %b expected 0", i, ack); end
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_mid got %b expected 1", busy); end
    bus_stop();
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got %b expected 0", busy); end
    if (exp_wr_q.size() != 0) begin failures++; $display("FAIL single_wr_missing got %0d pending expected 0", exp_wr_q.size()); end
  endtask

  task automatic test_wrong_addr();
    logic [7:0] wb[3];
    logic ack;
    int wr0;
    wb = '{8'h7A, 8'h30, 8'h08};
    wr0 = wr_seen;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b1) begin failures++; $display("FAIL wrong_nack[%0d] got %b expected 1", i, ack); end
    end
    bus_stop();
    checks += 3;
    if (oe_seen !== 1'b0)   begin failures++; $display("FAIL wrong_sda_oe got %b expected 0", oe_seen); end
    if (busy_seen !== 1'b0) begin failures++; $display("FAIL wrong_busy got %b expected 0", busy_seen); end
    if (wr_seen != wr0)     begin failures++; $display("FAIL wrong_wr_count got %0d expected %0d", wr_seen, wr0); end
  endtask

  task automatic test_burst();
    logic [7:0] wb[5];
    logic ack;
    wb = '{8'h78, 8'h38, 8'h00, 8'h00, 8'h01};
    exp_wr_q.push_back({16'h3800, 8'h00});
    exp_wr_q.push_back({16'h3801, 8'h01});
    bus_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL burst_ack[%0d] got %b expected 0", i, ack); end
    end
    bus_stop();
    wb = '{8'h78, 8'hFF, 8'hFF, 8'hAA, 8'hBB};
    exp_wr_q.push_back({16'hFFFF, 8'hAA});
    exp_wr_q.push_back({16'h0000, 8'hBB});
    bus_start();
    for (int i = 0; i < 5; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL wrap_ack[%0d] got %b expected 0", i, ack); end
    end
    bus_stop();
    checks += 2;
    if (exp_wr_q.size() != 0) begin failures++; $display("FAIL burst_wr_missing got %0d pending expected 0", exp_wr_q.size()); end
    if (rd_addr !== 16'h0001) begin failures++; $display("FAIL wrap_ptr got %h expected 0001", rd_addr); end
  endtask

  task automatic test_read();
    logic [7:0] wb[3];
    logic [7:0] b, exp;
    logic ack;
    wb = '{8'h78, 8'h30, 8'h0A};
    bus_start();
    for (int i = 0; i < 3; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL rdptr_ack[%0d] got %b expected 0", i, ack); end
    end
    bus_start();
    send_byte(8'h79, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL rd_dev_ack got %b expected 0", ack); end
    exp_rd_q.push_back(8'h56);
    read_byte(1'b1, b);
    exp = exp_rd_q.pop_front();
    checks++;
    if (b !== exp) begin failures++; $display("FAIL rd_bits got %b expected %b", b, exp); end
    wait_clk(5);
    checks += 3;
    if (rd_addr !== 16'h300A) begin failures++; $display("FAIL rd_addr got %h expected 300A", rd_addr); end
    if (sda_oe !== 1'b0)      begin failures++; $display("FAIL rd_release got %b expected 0", sda_oe); end
    if (busy !== 1'b1)        begin failures++; $display("FAIL rd_busy_nack got %b expected 1", busy); end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_after got %b expected 0", busy); end
  endtask

  task automatic test_read_burst();
    logic [7:0] b, exp;
    logic ack;
    bus_start();
    send_byte(8'h79, ack);
    checks++;
    if (ack !== 1'b0) begin failures++; $display("FAIL rdb_dev_ack got %b expected 0", ack); end
    exp_rd_q.push_back(reg_val(16'h300A));
    exp_rd_q.push_back(reg_val(16'h300B));
    for (int i = 0; i < 2; i++) begin
      read_byte((i == 1) ? 1'b1 : 1'b0, b);
      exp = exp_rd_q.pop_front();
      checks++;
      if (b !== exp) begin failures++; $display("FAIL rdb_byte[%0d] got %h expected %h", i, b, exp); end
    end
    bus_stop();
    checks++;
    if (rd_addr !== 16'h300B) begin failures++; $display("FAIL rdb_ptr got %h expected 300B", rd_addr); end
  endtask

  task automatic test_abort();
    logic [7:0] wb[4];
    logic ack;
    int wr0;
    wr0 = wr_seen;
    wb = '{8'h78, 8'h31, 8'h03, 8'h00};
    bus_start();
    for (int i = 0; i < 3; i++) send_byte(wb[i], ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    bus_stop();
    checks += 2;
    if (wr_seen != wr0) begin failures++; $display("FAIL abort_wr got %0d expected %0d", wr_seen, wr0); end
    if (busy !== 1'b0)  begin failures++; $display("FAIL abort_busy got %b expected 0", busy); end
    wb = '{8'h78, 8'h12, 8'h34, 8'h9C};
    exp_wr_q.push_back({16'h1234, 8'h9C});
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL abort_next_ack[%0d] got %b expected 0", i, ack); end
    end
    bus_stop();
    checks++;
    if (exp_wr_q.size() != 0) begin failures++; $display("FAIL abort_next_wr got %0d pending expected 0", exp_wr_q.size()); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] wb[4];
    logic [7:0] hb;
    logic ack;
    hb = 8'h55;
    bus_start();
    send_byte(8'h78, ack);
    for (int i = 7; i >= 0; i--) write_bit(hb[i]);
    checks++;
    if (sda_oe !== 1'b1) begin failures++; $display("FAIL ack_hi_driven got %b expected 1", sda_oe); end
    rst = 1'b1;
    wait_clk(1);
    checks += 3;
    if (sda_oe !== 1'b0)     begin failures++; $display("FAIL rst_mid_release got %b expected 0", sda_oe); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_mid_busy got %b expected 0", busy); end
    if (rd_addr !== 16'h0)   begin failures++; $display("FAIL rst_mid_ptr got %h expected 0000", rd_addr); end
    rst = 1'b0;
    write_bit(1'b1);
    oe_seen = 1'b0;
    write_bit(1'b0); write_bit(1'b1);
    checks++;
    if (oe_seen !== 1'b0) begin failures++; $display("FAIL rst_mid_ignore got %b expected 0", oe_seen); end
    bus_stop();
    wb = '{8'h78, 8'h00, 8'h05, 8'h77};
    exp_wr_q.push_back({16'h0005, 8'h77});
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(wb[i], ack);
      checks++;
      if (ack !== 1'b0) begin failures++; $display("FAIL rst_next_ack[%0d] got %b expected 0", i, ack); end
    end
    bus_stop();
    checks++;
    if (exp_wr_q.size() != 0) begin failures++; $display("FAIL rst_next_wr got %0d pending expected 0", exp_wr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wrong_addr();
    test_burst();
    test_read();
    test_read_burst();
    test_abort();
    test_rst_mid();
    wait_clk(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_slave_regif.md
SCCB_SLAVE_REGIF -- requirements
Module: sccb_slave_regif

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C, 7-bit device address (8-bit write address 0x78, read address 0x79).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of input synchronizer flops on scl_in/sda_in (min 2).
REQ-003 SHALL have port clk  input  1  system clock, at least 20x the SCL frequency; one clock domain; reset is synchronous and active-high.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port scl_in  input  1  bus SCL level, asynchronous.
REQ-006 SHALL have port sda_in  input  1  bus SDA level, asynchronous.
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release; never drives high.
REQ-008 SHALL have port wr_valid  output  1  one-clk pulse per accepted write data byte.
REQ-009 SHALL have port wr_addr  output  16  register address for wr_valid; held until next pulse.
REQ-010 SHALL have port wr_data  output  8  register data for wr_valid; held until next pulse.
REQ-011 SHALL have port rd_addr  output  16  current register pointer, for read lookup.
REQ-012 SHALL have port rd_data  input  8  register contents at rd_addr, valid 1 clk after rd_addr changes.
REQ-013 SHALL have port busy  output  1  high from START to STOP of an addressed transaction.

Function
REQ-014 SHALL pass scl_in/sda_in through SYNC_STAGES flops, then detect edges from one extra registered copy.
REQ-015 SHALL detect START as sda falling while scl high, STOP as sda rising while scl high, in every state including mid-byte.
REQ-016 SHALL sample SDA bits on synchronized scl rising edge, MSB first; SHALL change sda_oe only on the clk after a synchronized scl falling edge.
REQ-017 SHALL implement the states IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WDATA, ACK_W, RDATA, RACK, IGNORE.
REQ-018 IDLE -> DEV on START; DEV collects 8 bits, then ACK_DEV if addr[7:1]==DEV_ADDR, else IGNORE (sda_oe stays 0).
REQ-019 ACK_DEV SHALL hold sda_oe=1 for exactly the 9th SCL clock; next state REG_HI if R/W=0, RDATA if R/W=1.
REQ-020 REG_HI -> ACK_HI -> REG_LO -> ACK_LO SHALL load the pointer as {hi,lo}, with every byte ACKed.
REQ-021 After ACK_LO, WDATA SHALL collect 8 bits; on the 8th scl rise, pulse wr_valid with wr_addr=pointer and wr_data=byte, then enter ACK_W.
REQ-022 After ACK_W the pointer SHALL increment by 1, modulo 2^16 (0xFFFF wraps to 0x0000); return to WDATA for burst.
REQ-023 RDATA SHALL shift out rd_data latched at the first scl fall after ACK_DEV/RACK; bit=0 -> sda_oe=1, bit=1 -> sda_oe=0.
REQ-024 RACK SHALL release SDA and sample master ACK; ACK(0): pointer+1, reload, RDATA; NACK(1): IGNORE until STOP/START.
REQ-025 Repeated START in any state SHALL go to DEV, preserving the pointer (write reg address, Sr, read).
REQ-026 STOP in any state SHALL return to IDLE, release SDA, clear busy; a partial data byte SHALL NOT pulse wr_valid.
REQ-027 A STOP/START coincident with an scl edge SHALL take priority over bit sampling.
REQ-028 busy SHALL rise the clk after ACK_DEV entry and fall the clk after STOP detection.

Reset
REQ-029 On rst: state=IDLE, sda_oe=0, wr_valid=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0, synchronizer flops=1 (idle bus).
REQ-030 rst asserted mid-transaction SHALL release SDA the next clk; after release, the block SHALL ignore the bus until a new START.

Verification
REQ-031 Write 0x78,0x31,0x03,0x11,STOP -> 4 ACKs, one wr_valid with wr_addr=0x3103, wr_data=0x11; busy low after STOP.
REQ-032 Address 0x7A,0x30,0x08 -> sda_oe never 1, no wr_valid, busy stays 0.
REQ-033 Burst 0x78,0x38,0x00,0x00,0x01 -> wr_valid pairs (0x3800,0x00),(0x3801,0x01); burst at 0xFFFF -> next addr 0x0000.
REQ-034 0x78,0x30,0x0A,Sr,0x79, rd_data=0x56, master NACK -> SDA bits 01010110, rd_addr=0x300A, then SDA released.
REQ-035 STOP after 5 data bits, and rst during ACK_HI -> no wr_valid, sda_oe=0 within 1 clk, next transaction decodes normally.
